operand_entry: RTL and testbench
================================

// Module: operand_entry
// PURPOSE
//   Consumes single-cycle, debounced button pulses from the btn_filter
//   instances. Builds a DIGITS-wide decimal operand one digit at a time.
//   On ENTER, converts BCD to binary sequentially and presents the result to
//   the calculator ALU over a valid/ready handshake. It also exports the BCD
//   digits and the cursor position to the seven-segment display driver.
// PARAMETERS
//   DIGITS  4   number of decimal digits entered (>=2)
//   WIDTH   14  binary operand width; must satisfy 2**WIDTH > 10**DIGITS-1
//               (elaboration-time $error otherwise)
// PORTS
//   clk            in   1           system clock, all logic on rising edge
//   rst_n          in   1           asynchronous, active-low reset
//   inc_p          in   1           pulse: increment digit at cursor
//   dec_p          in   1           pulse: decrement digit at cursor
//   shift_p        in   1           pulse: move cursor one digit left
//   enter_p        in   1           pulse: commit operand
//   clr_p          in   1           pulse: clear entry / abort
//   operand        out  WIDTH       binary operand, valid when operand_valid=1
//   operand_valid  out  1           operand available to ALU
//   operand_ready  in   1           ALU accepts operand
//   digits_bcd     out  4*DIGITS    BCD digits; [3:0] is the least-significant digit
//   cursor         out  $clog2(DIGITS) index of the digit being edited
//   busy           out  1           high in CONV and VALID states
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=EDIT, all digits=0, cursor=0, acc=0,
//     operand=0, operand_valid=0, busy=0. Outputs take reset values without
//     waiting for a clock edge. Reset mid-CONV or mid-VALID discards all work.
//   - All outputs are registered. The pulse inputs are one clk wide. A level
//     held high acts once per cycle; no edge detection is done here.
//   - EDIT state. At most one action per cycle, with fixed priority
//     clr_p > enter_p > inc_p > dec_p > shift_p. Lower-priority pulses in the
//     same cycle are dropped.
//       clr_p:   all digits=0, cursor=0.
//       enter_p: go to CONV, acc=0, idx=DIGITS-1.
//       inc_p:   d[cursor] = (d==9) ? 0 : d+1.
//       dec_p:   d[cursor] = (d==0) ? 9 : d-1.
//       shift_p: cursor = (cursor==DIGITS-1) ? 0 : cursor+1.
//   - CONV state. Each cycle: acc = acc*10 + d[idx], then idx-1. The
//     multiply uses shift/add, (acc<<3)+(acc<<1), and the result is
//     truncated to WIDTH bits. After the idx==0 step: operand=acc,
//     operand_valid=1, go to VALID. inc/dec/shift/enter are ignored.
//   - Latency: enter_p is sampled on edge E. CONV occupies edges E+1 through
//     E+DIGITS. operand_valid goes high after edge E+DIGITS, i.e. DIGITS+1
//     cycles after the enter pulse.
//   - VALID state. operand and operand_valid stay stable until a clk edge
//     sees operand_valid & operand_ready. On that edge: operand_valid=0,
//     digits=0, cursor=0, go to EDIT. ready is allowed to be high before
//     valid. inc/dec/shift/enter are ignored.
//   - clr_p in CONV or VALID aborts: operand_valid=0 and digits cleared on
//     that edge, go to EDIT. clr wins over a simultaneous ready, so no
//     transfer occurs.
//   - digits_bcd and cursor reflect the live registers in all states. busy
//     is 1 iff state is CONV or VALID.
// TESTING
//   1. Assert rst_n=0 between edges -> outputs zero immediately. Release, no
//      pulses for 10 cycles -> no output change.
//   2. Enter 1,2,3,4 (MS to LS) with inc/shift, then enter_p ->
//      digits_bcd=16'h1234 before enter. operand_valid rises exactly 5 cycles
//      after enter with operand=14'd1234. Hold ready=0 for 8 cycles -> values
//      stable. ready=1 -> valid drops next edge, digits_bcd=0.
//   3. Wrap: dec_p at digit 0 -> 9; inc_p at 9 -> 0. shift_p x4 from
//      cursor 0 -> cursor 0. Enter 9999 -> operand=14'd9999.
//   4. Simultaneous inc_p+clr_p in EDIT -> digits 0, no increment.
//      inc_p+dec_p -> +1 only. inc_p during CONV -> digits unchanged,
//      operand correct.
//   5. clr_p during CONV, and separately during VALID with ready=1 ->
//      operand_valid=0, no transfer, EDIT with digits 0. rst_n low mid-CONV
//      -> busy=0 immediately.
//   6. ready held high before enter -> handshake completes on the first
//      VALID cycle: valid high for exactly one cycle.

Source files
------------

// File: rtl/operand_entry.sv
// Decimal operand entry: edits BCD digits from button pulses, converts
// to binary on enter and offers the result over a valid/ready handshake.
module operand_entry #(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 14
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      inc_p,
    input  logic                      dec_p,
    input  logic                      shift_p,
    input  logic                      enter_p,
    input  logic                      clr_p,
    output logic [WIDTH-1:0]          operand,
    output logic                      operand_valid,
    input  logic                      operand_ready,
    output logic [4*DIGITS-1:0]       digits_bcd,
    output logic [$clog2(DIGITS)-1:0] cursor,
    output logic                      busy
);

    localparam int CW = $clog2(DIGITS);
    localparam longint unsigned POW = 64'd10 ** DIGITS;
    localparam longint unsigned CAP = 64'd1 << WIDTH;

    if (CAP <= POW - 64'd1) begin : g_width_chk
        $error("operand_entry: WIDTH too small for DIGITS");
    end

    typedef enum logic [1:0] {
        EDIT,
        CONV,
        VALID
    } state_t;

    state_t                     state_q, state_d;
    logic [DIGITS-1:0][3:0]     dig_q, dig_d;
    logic [CW-1:0]              cur_q, cur_d;
    logic [CW-1:0]              idx_q, idx_d;
    logic [WIDTH-1:0]           acc_q, acc_d;
    logic [WIDTH-1:0]           op_q, op_d;
    logic                       vld_q, vld_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EDIT;
            dig_q   <= '0;
            cur_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            op_q    <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dig_q   <= dig_d;
            cur_q   <= cur_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        cur_d   = cur_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        op_d    = op_q;
        vld_d   = vld_q;
        unique case (state_q)
            EDIT: begin
                if (clr_p) begin
                    dig_d = '0;
                    cur_d = '0;
                end else if (enter_p) begin
                    state_d = CONV;
                    acc_d   = '0;
                    idx_d   = CW'(DIGITS - 1);
                end else if (inc_p) begin
                    dig_d[cur_q] = (dig_q[cur_q] == 4'd9) ?
                                   4'd0 : dig_q[cur_q] + 4'd1;
                end else if (dec_p) begin
                    dig_d[cur_q] = (dig_q[cur_q] == 4'd0) ?
                                   4'd9 : dig_q[cur_q] - 4'd1;
                end else if (shift_p) begin
                    cur_d = (cur_q == CW'(DIGITS - 1)) ?
                            '0 : cur_q + 1'b1;
                end
            end
            CONV: begin
                if (clr_p) begin
                    state_d = EDIT;
                    dig_d   = '0;
                    cur_d   = '0;
                    vld_d   = 1'b0;
                end else begin
                    // acc*10 as (acc<<3)+(acc<<1), MS digit first
                    acc_d = (acc_q << 3) + (acc_q << 1) +
                            WIDTH'(dig_q[idx_q]);
                    idx_d = idx_q - 1'b1;
                    if (idx_q == '0) begin
                        op_d    = acc_d;
                        vld_d   = 1'b1;
                        state_d = VALID;
                    end
                end
            end
            VALID: begin
                if (clr_p || operand_ready) begin
                    state_d = EDIT;
                    dig_d   = '0;
                    cur_d   = '0;
                    vld_d   = 1'b0;
                end
            end
            default: state_d = EDIT;
        endcase
    end

    assign operand       = op_q;
    assign operand_valid = vld_q;
    assign digits_bcd    = dig_q;
    assign cursor        = cur_q;
    assign busy          = (state_q != EDIT);

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry: editing, wrap, priority,
// conversion latency, handshake, abort and async reset.
module tb_operand_entry;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inc_p, dec_p, shift_p, enter_p, clr_p;
    logic [13:0] operand;
    logic        operand_valid;
    logic        operand_ready;
    logic [15:0] digits_bcd;
    logic [1:0]  cursor;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int lat;

    localparam logic [4:0] CLR = 5'b10000;
    localparam logic [4:0] ENT = 5'b01000;
    localparam logic [4:0] INC = 5'b00100;
    localparam logic [4:0] DEC = 5'b00010;
    localparam logic [4:0] SHF = 5'b00001;

    operand_entry #(.DIGITS(4), .WIDTH(14)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inc_p         (inc_p),
        .dec_p         (dec_p),
        .shift_p       (shift_p),
        .enter_p       (enter_p),
        .clr_p         (clr_p),
        .operand       (operand),
        .operand_valid (operand_valid),
        .operand_ready (operand_ready),
        .digits_bcd    (digits_bcd),
        .cursor        (cursor),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulses(input logic [4:0] v);
        {clr_p, enter_p, inc_p, dec_p, shift_p} = v;
        tick();
        {clr_p, enter_p, inc_p, dec_p, shift_p} = '0;
    endtask

    task automatic set_digits(input int d3, input int d2,
                              input int d1, input int d0);
        int d[4];
        d = '{d0, d1, d2, d3};
        for (int k = 0; k < 4; k++) begin
            repeat (d[k]) pulses(INC);
            pulses(SHF);
        end
    endtask

    task automatic enter_and_wait(output int n);
        pulses(ENT);
        n = 1;
        while (!operand_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        operand_ready = 1'b0;
        {clr_p, enter_p, inc_p, dec_p, shift_p} = '0;
        #12;
        chk("rst_valid", 32'(operand_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_operand", 32'(operand), 0);
        rst_n = 1'b1;
        tick();
        repeat (10) tick();
        chk("idle_digits", 32'(digits_bcd), 0);
        chk("idle_cursor", 32'(cursor), 0);
        chk("idle_valid", 32'(operand_valid), 0);

        pulses(INC);
        pulses(SHF);
        chk("pre_rst_digits", 32'(digits_bcd), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_digits", 32'(digits_bcd), 0);
        chk("async_rst_cursor", 32'(cursor), 0);
        rst_n = 1'b1;
        tick();

        set_digits(1, 2, 3, 4);
        chk("edit_1234", 32'(digits_bcd), 32'h1234);
        chk("edit_cursor", 32'(cursor), 0);
        enter_and_wait(lat);
        chk("lat_1234", 32'(lat), 5);
        chk("op_1234", 32'(operand), 1234);
        chk("busy_valid", 32'(busy), 1);
        repeat (8) tick();
        chk("hold_valid", 32'(operand_valid), 1);
        chk("hold_op", 32'(operand), 1234);
        chk("hold_digits", 32'(digits_bcd), 32'h1234);
        operand_ready = 1'b1;
        tick();
        operand_ready = 1'b0;
        chk("xfer_valid", 32'(operand_valid), 0);
        chk("xfer_digits", 32'(digits_bcd), 0);
        chk("xfer_busy", 32'(busy), 0);

        pulses(DEC);
        chk("wrap_dec", 32'(digits_bcd), 32'h0009);
        pulses(INC);
        chk("wrap_inc", 32'(digits_bcd), 32'h0000);
        pulses(SHF);
        pulses(SHF);
        pulses(SHF);
        chk("shift3", 32'(cursor), 3);
        pulses(SHF);
        chk("shift_wrap", 32'(cursor), 0);
        set_digits(9, 9, 9, 9);
        chk("edit_9999", 32'(digits_bcd), 32'h9999);
        enter_and_wait(lat);
        chk("lat_9999", 32'(lat), 5);
        chk("op_9999", 32'(operand), 9999);
        operand_ready = 1'b1;
        tick();
        operand_ready = 1'b0;

        pulses(CLR | INC);
        chk("clr_over_inc", 32'(digits_bcd), 0);
        pulses(INC | DEC);
        chk("inc_over_dec", 32'(digits_bcd), 32'h1);
        pulses(SHF);
        pulses(INC);
        pulses(INC);
        chk("edit_21", 32'(digits_bcd), 32'h0021);
        pulses(ENT);
        lat = 1;
        pulses(INC);
        lat++;
        chk("conv_inc_ignored", 32'(digits_bcd), 32'h0021);
        while (!operand_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("lat_21", 32'(lat), 5);
        chk("op_21", 32'(operand), 21);
        operand_ready = 1'b1;
        tick();
        operand_ready = 1'b0;

        pulses(INC);
        pulses(ENT);
        tick();
        chk("conv_busy", 32'(busy), 1);
        pulses(CLR);
        chk("conv_clr_busy", 32'(busy), 0);
        chk("conv_clr_digits", 32'(digits_bcd), 0);
        repeat (6) tick();
        chk("conv_clr_novalid", 32'(operand_valid), 0);

        pulses(INC);
        enter_and_wait(lat);
        chk("pre_abort_valid", 32'(operand_valid), 1);
        operand_ready = 1'b1;
        pulses(CLR);
        operand_ready = 1'b0;
        chk("abort_valid", 32'(operand_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_digits", 32'(digits_bcd), 0);

        pulses(INC);
        pulses(ENT);
        tick();
        chk("mid_conv_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_conv_busy", 32'(busy), 0);
        chk("rst_conv_digits", 32'(digits_bcd), 0);
        rst_n = 1'b1;
        tick();

        pulses(INC);
        pulses(SHF);
        pulses(INC);
        chk("edit_11", 32'(digits_bcd), 32'h0011);
        operand_ready = 1'b1;
        enter_and_wait(lat);
        chk("lat_11", 32'(lat), 5);
        chk("op_11", 32'(operand), 11);
        tick();
        operand_ready = 1'b0;
        chk("one_cycle_valid", 32'(operand_valid), 0);
        chk("one_cycle_digits", 32'(digits_bcd), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
